// File: rtl/mf_clken_gen.sv
// Multi-channel fractional clock-enable generator with per-channel phase and PLL lock sequencing.
// Latency: enables are registered and appear the cycle after the accumulate that produced them.
// No backpressure: free-running; src_locked drop or sync realigns all channels to PHASE.
module mf_clken_gen #(
   parameter int                          CHANNELS    = 2,
   parameter int                          ACC_W       = 16,
   parameter logic [CHANNELS*ACC_W-1:0]   NUM         = {16'd1, 16'd1},
   parameter logic [CHANNELS*ACC_W-1:0]   DEN         = {16'd8, 16'd8},
   parameter logic [CHANNELS*ACC_W-1:0]   PHASE       = {16'd4, 16'd0},
   parameter int                          LOCK_CYCLES = 1024
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                src_locked,
   input  logic                sync,
   output logic [CHANNELS-1:0] ce,
   output logic [CHANNELS-1:0] ce_mid,
   output logic                locked
);

   localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_phase;
   logic             do_acc;
   logic             locked_d;

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         locked  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         locked  <= locked_d;
      end
   end

   // Outside RUN the accumulators are pinned to PHASE, so entering RUN always starts aligned.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      load_phase = 1'b0;
      do_acc     = 1'b0;
      locked_d   = 1'b0;
      case (state_q)
         IDLE: begin
            load_phase = 1'b1;
            if (src_locked) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         SETTLE: begin
            load_phase = 1'b1;
            if (!src_locked) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = RUN;
               locked_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (!src_locked) begin
               state_d    = IDLE;
               load_phase = 1'b1;
            end else begin
               locked_d = 1'b1;
               if (sync) load_phase = 1'b1;
               else      do_acc     = 1'b1;
            end
         end
         default: begin
            state_d    = IDLE;
            load_phase = 1'b1;
         end
      endcase
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      localparam logic [ACC_W:0]   NUM_I = {1'b0, NUM[i*ACC_W +: ACC_W]};
      localparam logic [ACC_W:0]   DEN_I = {1'b0, DEN[i*ACC_W +: ACC_W]};
      localparam logic [ACC_W:0]   H_I   = DEN_I >> 1;
      localparam logic [ACC_W-1:0] PH_I  = PHASE[i*ACC_W +: ACC_W];

      logic [ACC_W-1:0] acc_r;
      logic             ce_r;
      logic             mid_r;
      logic [ACC_W:0]   p0;
      logic [ACC_W:0]   p1;
      logic             wrap;
      logic             mid;

      // One extra bit of headroom keeps acc+NUM and DEN+H exact.
      assign p0   = {1'b0, acc_r};
      assign p1   = p0 + NUM_I;
      assign wrap = (p1 >= DEN_I);
      assign mid  = ((p0 < H_I) && (p1 >= H_I)) || (p1 >= (DEN_I + H_I));

      always_ff @(posedge refclk) begin
         if (rst || load_phase) begin
            acc_r <= PH_I;
            ce_r  <= 1'b0;
            mid_r <= 1'b0;
         end else if (do_acc) begin
            acc_r <= wrap ? ACC_W'(p1 - DEN_I) : p1[ACC_W-1:0];
            ce_r  <= wrap;
            mid_r <= mid;
         end
      end

      assign ce[i]     = ce_r;
      assign ce_mid[i] = mid_r;
   end

endmodule

// File: tb/tb_mf_clken_gen.sv
// Scoreboarded bench: default 2-channel instance plus a 3-channel instance (NUM/DEN 3/8, 5/5, 0/8).
module tb_mf_clken_gen;

   typedef struct packed {
      logic       lk;
      logic [1:0] ce_a;
      logic [1:0] mid_a;
      logic [2:0] ce_b;
      logic [2:0] mid_b;
      logic       cnt;
   } exp_t;

   // Channel 0 of instance B (NUM=3, DEN=8): ce after accumulates 3,6,8; ce_mid after 2,4,7 (mod 8).
   localparam logic [7:0] CE_B0_TAB  = 8'h49;
   localparam logic [7:0] MID_B0_TAB = 8'h94;

   logic       refclk;
   logic       rst;
   logic       src_locked;
   logic       sync;
   logic [1:0] ce_a, mid_a;
   logic [2:0] ce_b, mid_b;
   logic       locked_a, locked_b;

   exp_t q[$];
   exp_t e_mon;
   int   n_chk   = 0;
   int   n_pass  = 0;
   int   pulse_b0 = 0;
   int   pulse_b1 = 0;
   int   k_run   = 0;
   int   cyc     = 0;
   logic done    = 1'b0;

   mf_clken_gen u_dut_a (
      .refclk     (refclk),
      .rst        (rst),
      .src_locked (src_locked),
      .sync       (sync),
      .ce         (ce_a),
      .ce_mid     (mid_a),
      .locked     (locked_a)
   );

   mf_clken_gen #(
      .CHANNELS    (3),
      .ACC_W       (16),
      .NUM         ({16'd0, 16'd5, 16'd3}),
      .DEN         ({16'd8, 16'd5, 16'd8}),
      .PHASE       ({16'd0, 16'd0, 16'd0}),
      .LOCK_CYCLES (1024)
   ) u_dut_b (
      .refclk     (refclk),
      .rst        (rst),
      .src_locked (src_locked),
      .sync       (sync),
      .ce         (ce_b),
      .ce_mid     (mid_b),
      .locked     (locked_b)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not complete, checks=%0d", n_chk);
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t zero_exp();
      exp_t e;
      e = '0;
      return e;
   endfunction

   function automatic exp_t lock_exp();
      exp_t e;
      e    = '0;
      e.lk = 1'b1;
      return e;
   endfunction

   function automatic exp_t run_exp(input int k, input logic cnt);
      exp_t       e;
      logic [2:0] m;
      m       = 3'(k % 8);
      e       = '0;
      e.lk    = 1'b1;
      e.cnt   = cnt;
      e.ce_a  = {m == 3'd4, m == 3'd0};
      e.mid_a = {m == 3'd0, m == 3'd4};
      e.ce_b  = {1'b0, 1'b1, CE_B0_TAB[m]};
      e.mid_b = {1'b0, 1'b1, MID_B0_TAB[m]};
      return e;
   endfunction

   task automatic step(input logic lk, input logic sy, input logic rs, input exp_t e);
      @(negedge refclk);
      src_locked = lk;
      sync       = sy;
      rst        = rs;
      @(posedge refclk);
      q.push_back(e);
   endtask

   // One IDLE->SETTLE edge, 1023 further SETTLE edges, then the edge that enters RUN.
   task automatic settle_full(input int sync_at);
      for (int i = 0; i < 1024; i++) step(1'b1, (i == sync_at), 1'b0, zero_exp());
      step(1'b1, 1'b0, 1'b0, lock_exp());
      k_run = 0;
   endtask

   task automatic run_n(input int n, input logic cnt);
      for (int i = 0; i < n; i++) begin
         k_run = k_run + 1;
         step(1'b1, 1'b0, 1'b0, run_exp(k_run, cnt));
      end
   endtask

   initial begin
      rst        = 1'b1;
      src_locked = 1'b1;
      sync       = 1'b0;
      step(1'b1, 1'b0, 1'b1, zero_exp());
      step(1'b1, 1'b0, 1'b1, zero_exp());
      settle_full(-1);
      run_n(800, 1'b1);
      // ch0 of instance A sits at acc=5; sync realigns both channels.
      run_n(5, 1'b0);
      step(1'b1, 1'b1, 1'b0, lock_exp());
      k_run = 0;
      run_n(16, 1'b0);
      // One-cycle lock drop, then full resettle (sync during IDLE is ignored).
      step(1'b0, 1'b0, 1'b0, zero_exp());
      settle_full(0);
      run_n(10, 1'b0);
      // Drop at settle count 500: counter must restart from zero.
      step(1'b0, 1'b0, 1'b0, zero_exp());
      for (int i = 0; i < 501; i++) step(1'b1, 1'b0, 1'b0, zero_exp());
      step(1'b0, 1'b0, 1'b0, zero_exp());
      settle_full(300);
      run_n(10, 1'b0);
      // sync together with a lock drop: the drop wins.
      step(1'b0, 1'b1, 1'b0, zero_exp());
      step(1'b0, 1'b0, 1'b0, zero_exp());
      settle_full(-1);
      run_n(5, 1'b0);
      // Reset in RUN while instance B ch1 ce is high.
      step(1'b1, 1'b0, 1'b1, zero_exp());
      settle_full(-1);
      run_n(9, 1'b0);
      done = 1'b1;
   end

   always @(negedge refclk) begin
      cyc = cyc + 1;
      if (q.size() > 0) begin
         e_mon = q.pop_front();
         n_chk = n_chk + 1;
         if ({locked_a, locked_b, ce_a, mid_a, ce_b, mid_b} ===
             {e_mon.lk, e_mon.lk, e_mon.ce_a, e_mon.mid_a, e_mon.ce_b, e_mon.mid_b}) begin
            n_pass = n_pass + 1;
         end else begin
            $display("FAIL outputs cyc=%0d got lk=%b/%b ce_a=%b mid_a=%b ce_b=%b mid_b=%b want lk=%b ce_a=%b mid_a=%b ce_b=%b mid_b=%b",
                     cyc, locked_a, locked_b, ce_a, mid_a, ce_b, mid_b,
                     e_mon.lk, e_mon.ce_a, e_mon.mid_a, e_mon.ce_b, e_mon.mid_b);
         end
         if (e_mon.cnt) begin
            pulse_b0 = pulse_b0 + int'(ce_b[0]);
            pulse_b1 = pulse_b1 + int'(ce_b[1]);
         end
      end else if (done) begin
         n_chk = n_chk + 1;
         if (pulse_b0 == 300) n_pass = n_pass + 1;
         else $display("FAIL pulse_count_3_8 got %0d want 300", pulse_b0);
         n_chk = n_chk + 1;
         if (pulse_b1 == 800) n_pass = n_pass + 1;
         else $display("FAIL pulse_count_5_5 got %0d want 800", pulse_b1);
         $display("%0d/%0d checks passed", n_pass, n_chk);
         $finish;
      end
   end

endmodule
